// File: rtl/multicycle_ctrl.sv
// Multi-cycle controller for the reduced RISC-V datapath: fetches over a
// valid/ready handshake, decodes ADDI/ADD/BNE, and drives one EXEC cycle per instruction.
`timescale 1ns/1ps

module multicycle_ctrl #(
  parameter int DATA_WIDTH        = 32,
  parameter int REG_ADDRESS_WIDTH = 5,
  parameter int RETIRE_WIDTH      = 16
) (
  input  logic                         clk,
  input  logic                         rst,
  input  logic                         run,
  output logic                         imem_req,
  input  logic                         imem_ready,
  input  logic [DATA_WIDTH-1:0]        imem_instr,
  input  logic                         EQ,
  output logic [DATA_WIDTH-1:0]        ImmOp,
  output logic [REG_ADDRESS_WIDTH-1:0] rs1,
  output logic [REG_ADDRESS_WIDTH-1:0] rs2,
  output logic [REG_ADDRESS_WIDTH-1:0] rd,
  output logic                         RegWrite,
  output logic                         ALUsrc,
  output logic [2:0]                   ALUctrl,
  output logic                         PCsrc,
  output logic                         pc_en,
  output logic                         halted,
  output logic                         trap,
  output logic [RETIRE_WIDTH-1:0]      retired
);

  localparam logic [6:0] OP_IMM    = 7'b0010011;
  localparam logic [6:0] OP_REG    = 7'b0110011;
  localparam logic [6:0] OP_BRANCH = 7'b1100011;
  localparam logic [DATA_WIDTH-1:0] ECALL_WORD = DATA_WIDTH'(32'h0000_0073);

  typedef enum logic [2:0] {
    S_IDLE,
    S_FETCH,
    S_DECODE,
    S_EXEC,
    S_HALT,
    S_TRAP
  } state_t;

  state_t                         state_q, state_d;
  logic [DATA_WIDTH-1:0]          instr_q, instr_d;
  logic [DATA_WIDTH-1:0]          imm_q, imm_d;
  logic [REG_ADDRESS_WIDTH-1:0]   rs1_q, rs1_d;
  logic [REG_ADDRESS_WIDTH-1:0]   rs2_q, rs2_d;
  logic [REG_ADDRESS_WIDTH-1:0]   rd_q, rd_d;
  logic                           alu_src_q, alu_src_d;
  logic [2:0]                     alu_ctrl_q, alu_ctrl_d;
  logic                           is_bne_q, is_bne_d;
  logic                           reg_write_q, reg_write_d;
  logic                           pc_en_q, pc_en_d;
  logic                           imem_req_q, imem_req_d;
  logic                           halted_q, halted_d;
  logic                           trap_q, trap_d;
  logic [RETIRE_WIDTH-1:0]        retired_q, retired_d;

  logic [6:0]            opcode;
  logic [2:0]            funct3;
  logic [6:0]            funct7;
  logic                  dec_addi, dec_add, dec_bne, dec_ecall;
  logic [DATA_WIDTH-1:0] dec_imm;

  function automatic logic [DATA_WIDTH-1:0] sext_i(input logic [11:0] v);
    return {{(DATA_WIDTH-12){v[11]}}, v};
  endfunction

  function automatic logic [DATA_WIDTH-1:0] sext_b(input logic [12:0] v);
    return {{(DATA_WIDTH-13){v[12]}}, v};
  endfunction

  assign opcode    = instr_q[6:0];
  assign funct3    = instr_q[14:12];
  assign funct7    = instr_q[31:25];
  assign dec_addi  = (opcode == OP_IMM) && (funct3 == 3'b000);
  assign dec_add   = (opcode == OP_REG) && (funct3 == 3'b000) && (funct7 == 7'b0000000);
  assign dec_bne   = (opcode == OP_BRANCH) && (funct3 == 3'b001);
  assign dec_ecall = (instr_q == ECALL_WORD);

  always_comb begin
    dec_imm = '0;
    if (dec_addi) begin
      dec_imm = sext_i(instr_q[31:20]);
    end else if (dec_bne) begin
      dec_imm = sext_b({instr_q[31], instr_q[7], instr_q[30:25], instr_q[11:8], 1'b0});
    end
  end

  // Strobes are computed for the state being entered so they appear registered in it.
  always_comb begin
    state_d     = state_q;
    instr_d     = instr_q;
    imm_d       = imm_q;
    rs1_d       = rs1_q;
    rs2_d       = rs2_q;
    rd_d        = rd_q;
    alu_src_d   = alu_src_q;
    alu_ctrl_d  = alu_ctrl_q;
    is_bne_d    = is_bne_q;
    reg_write_d = 1'b0;
    pc_en_d     = 1'b0;
    imem_req_d  = 1'b0;
    halted_d    = halted_q;
    trap_d      = trap_q;
    retired_d   = retired_q;

    unique case (state_q)
      S_IDLE: begin
        if (run) begin
          state_d    = S_FETCH;
          imem_req_d = 1'b1;
        end
      end
      S_FETCH: begin
        if (imem_ready) begin
          instr_d = imem_instr;
          state_d = S_DECODE;
        end else begin
          imem_req_d = 1'b1;
        end
      end
      S_DECODE: begin
        rs1_d      = REG_ADDRESS_WIDTH'(instr_q[19:15]);
        rs2_d      = REG_ADDRESS_WIDTH'(instr_q[24:20]);
        rd_d       = REG_ADDRESS_WIDTH'(instr_q[11:7]);
        imm_d      = dec_imm;
        alu_src_d  = dec_addi;
        alu_ctrl_d = dec_bne ? 3'b001 : 3'b000;
        is_bne_d   = dec_bne;
        if (dec_ecall) begin
          state_d  = S_HALT;
          halted_d = 1'b1;
        end else if (!(dec_addi || dec_add || dec_bne)) begin
          state_d = S_TRAP;
          trap_d  = 1'b1;
        end else begin
          state_d     = S_EXEC;
          pc_en_d     = 1'b1;
          reg_write_d = (dec_addi || dec_add) && (instr_q[11:7] != 5'd0);
        end
      end
      S_EXEC: begin
        retired_d = retired_q + 1'b1;
        if (run) begin
          state_d    = S_FETCH;
          imem_req_d = 1'b1;
        end else begin
          state_d = S_IDLE;
        end
      end
      S_HALT, S_TRAP: begin
        state_d = state_q;
      end
      default: begin
        state_d = S_IDLE;
      end
    endcase
  end

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state_q     <= S_IDLE;
      instr_q     <= '0;
      imm_q       <= '0;
      rs1_q       <= '0;
      rs2_q       <= '0;
      rd_q        <= '0;
      alu_src_q   <= 1'b0;
      alu_ctrl_q  <= 3'b000;
      is_bne_q    <= 1'b0;
      reg_write_q <= 1'b0;
      pc_en_q     <= 1'b0;
      imem_req_q  <= 1'b0;
      halted_q    <= 1'b0;
      trap_q      <= 1'b0;
      retired_q   <= '0;
    end else begin
      state_q     <= state_d;
      instr_q     <= instr_d;
      imm_q       <= imm_d;
      rs1_q       <= rs1_d;
      rs2_q       <= rs2_d;
      rd_q        <= rd_d;
      alu_src_q   <= alu_src_d;
      alu_ctrl_q  <= alu_ctrl_d;
      is_bne_q    <= is_bne_d;
      reg_write_q <= reg_write_d;
      pc_en_q     <= pc_en_d;
      imem_req_q  <= imem_req_d;
      halted_q    <= halted_d;
      trap_q      <= trap_d;
      retired_q   <= retired_d;
    end
  end

  assign imem_req = imem_req_q;
  assign ImmOp    = imm_q;
  assign rs1      = rs1_q;
  assign rs2      = rs2_q;
  assign rd       = rd_q;
  assign RegWrite = reg_write_q;
  assign ALUsrc   = alu_src_q;
  assign ALUctrl  = alu_ctrl_q;
  assign pc_en    = pc_en_q;
  assign halted   = halted_q;
  assign trap     = trap_q;
  assign retired  = retired_q;
  // The branch decision follows EQ live during EXEC, so it cannot be registered.
  assign PCsrc    = (state_q == S_EXEC) && is_bne_q && !EQ;

endmodule

// File: tb/tb_multicycle_ctrl.sv
// Scoreboard bench for multicycle_ctrl: directed instructions push expected EXEC/halt/trap
// responses; a negedge monitor pops and compares whenever the DUT presents one.
`timescale 1ns/1ps

module tb_multicycle_ctrl;

  logic        clk = 1'b0;
  logic        rst = 1'b1;
  logic        run = 1'b0;
  logic        imem_ready = 1'b0;
  logic [31:0] imem_instr = '0;
  logic        EQ = 1'b0;
  logic        imem_req;
  logic [31:0] ImmOp;
  logic [4:0]  rs1, rs2, rd;
  logic        RegWrite, ALUsrc, PCsrc, pc_en, halted, trap;
  logic [2:0]  ALUctrl;
  logic [15:0] retired;

  multicycle_ctrl #(.DATA_WIDTH(32), .REG_ADDRESS_WIDTH(5), .RETIRE_WIDTH(16)) dut (
    .clk(clk), .rst(rst), .run(run),
    .imem_req(imem_req), .imem_ready(imem_ready), .imem_instr(imem_instr),
    .EQ(EQ), .ImmOp(ImmOp), .rs1(rs1), .rs2(rs2), .rd(rd),
    .RegWrite(RegWrite), .ALUsrc(ALUsrc), .ALUctrl(ALUctrl), .PCsrc(PCsrc),
    .pc_en(pc_en), .halted(halted), .trap(trap), .retired(retired)
  );

  always #5 clk = ~clk;

  int cyc = 0;
  always @(posedge clk) cyc <= cyc + 1;

  typedef struct {
    int         kind;      // 0 = exec, 1 = halt, 2 = trap
    logic [4:0] rs1, rs2, rd;
    logic       chk_rs2;
    logic [31:0] imm;
    logic       chk_imm;
    logic       alusrc;
    logic [2:0] aluctrl;
    logic       regwrite;
    logic       pcsrc;
  } exp_t;

  exp_t sb[$];
  exp_t me;
  int   n_total = 0;
  int   n_pass  = 0;
  int   exp_ret = 0;
  bit   hseen = 0, tseen = 0;

  task automatic check(input string name, input logic [95:0] act, input logic [95:0] exp);
    n_total++;
    if (act === exp) n_pass++;
    else $display("FAIL %s: got %0h expected %0h", name, act, exp);
  endtask

  function automatic logic [95:0] outs_vec();
    return {imem_req, ImmOp, rs1, rs2, rd, RegWrite, ALUsrc, ALUctrl, PCsrc,
            pc_en, halted, trap, retired};
  endfunction

  function automatic exp_t mk(input int kind, input logic [4:0] r1, input logic [4:0] r2,
                              input logic c2, input logic [4:0] d, input logic [31:0] imm,
                              input logic ci, input logic src, input logic [2:0] ctl,
                              input logic rw, input logic pcs);
    exp_t e;
    e.kind = kind; e.rs1 = r1; e.rs2 = r2; e.chk_rs2 = c2; e.rd = d; e.imm = imm;
    e.chk_imm = ci; e.alusrc = src; e.aluctrl = ctl; e.regwrite = rw; e.pcsrc = pcs;
    return e;
  endfunction

  // Monitor: pops one expectation per EXEC cycle or per halt/trap assertion.
  always @(negedge clk) begin
    if (rst) begin
      hseen = 0;
      tseen = 0;
    end else begin
      if (pc_en) begin
        if (sb.size() == 0) check("unexpected_exec", 1, 0);
        else begin
          me = sb.pop_front();
          check("exec_kind", me.kind, 0);
          check("rs1", rs1, me.rs1);
          check("rd", rd, me.rd);
          if (me.chk_rs2) check("rs2", rs2, me.rs2);
          if (me.chk_imm) check("ImmOp", ImmOp, me.imm);
          check("ALUsrc", ALUsrc, me.alusrc);
          check("ALUctrl", ALUctrl, me.aluctrl);
          check("RegWrite", RegWrite, me.regwrite);
          check("PCsrc", PCsrc, me.pcsrc);
        end
      end else begin
        check("idle_ctrl", {RegWrite, PCsrc}, 2'b00);
      end
      if (halted && !hseen) begin
        hseen = 1;
        if (sb.size() == 0) check("unexpected_halt", 1, 0);
        else begin
          me = sb.pop_front();
          check("halt_kind", me.kind, 1);
        end
      end
      if (trap && !tseen) begin
        tseen = 1;
        if (sb.size() == 0) check("unexpected_trap", 1, 0);
        else begin
          me = sb.pop_front();
          check("trap_kind", me.kind, 2);
        end
      end
    end
  end

  task automatic wait_req();
    int n = 0;
    while (!imem_req && n < 20) begin
      @(negedge clk);
      n++;
    end
  endtask

  task automatic issue(input logic [31:0] ins, input int stall, input logic eq_v,
                       input exp_t e, input bit next_req, input string tag);
    int n, c0;
    logic seen;
    wait_req();
    check({tag, "_req"}, imem_req, 1);
    c0 = cyc;
    EQ = eq_v;
    sb.push_back(e);
    for (int k = 0; k < stall; k++) begin
      imem_ready = 1'b0;
      @(negedge clk);
      check({tag, "_stall_hold"}, {imem_req, pc_en, RegWrite}, 3'b100);
    end
    imem_ready = 1'b1;
    imem_instr = ins;
    @(negedge clk);
    imem_ready = 1'b0;
    imem_instr = '0;
    n = 0;
    while (!(pc_en || halted || trap) && n < 10) begin
      @(negedge clk);
      n++;
    end
    check({tag, "_done"}, pc_en | halted | trap, 1);
    if (e.kind == 0) begin
      check({tag, "_latency"}, cyc - c0, stall + 2);
      exp_ret++;
      @(negedge clk);
      check({tag, "_pulse"}, {pc_en, RegWrite}, 2'b00);
      check({tag, "_retired"}, retired, exp_ret);
      check({tag, "_next_req"}, imem_req, next_req);
    end else begin
      seen = 1'b0;
      for (int k = 0; k < 5; k++) begin
        @(negedge clk);
        seen = seen | imem_req | pc_en | RegWrite;
      end
      check({tag, "_stopped"}, seen, 0);
      check({tag, "_retired"}, retired, exp_ret);
    end
  endtask

  task automatic do_reset(input string tag);
    @(negedge clk);
    rst = 1'b1;
    #1;
    check({tag, "_zero"}, outs_vec(), 0);
    @(negedge clk);
    @(negedge clk);
    rst = 1'b0;
    exp_ret = 0;
  endtask

  initial begin
    #100000;
    $display("FAIL watchdog: simulation did not finish, expected completion");
    $fatal(1);
  end

  initial begin
    logic seen;
    int   n;
    repeat (2) @(negedge clk);
    check("reset_state", outs_vec(), 0);
    rst = 1'b0;
    run = 1'b1;

    issue(32'h00500513, 0, 1'b0, mk(0, 5'd0, 5'd0, 1'b0, 5'd10, 32'h5, 1'b1, 1'b1, 3'b000, 1'b1, 1'b0), 1, "addi");
    issue(32'h007302B3, 0, 1'b0, mk(0, 5'd6, 5'd7, 1'b1, 5'd5, 32'h0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0), 1, "add");
    issue(32'hFE051EE3, 4, 1'b0, mk(0, 5'd10, 5'd0, 1'b1, 5'd29, 32'hFFFFFFFC, 1'b1, 1'b0, 3'b001, 1'b0, 1'b1), 1, "bne_ne");
    issue(32'hFE051EE3, 0, 1'b1, mk(0, 5'd10, 5'd0, 1'b1, 5'd29, 32'hFFFFFFFC, 1'b1, 1'b0, 3'b001, 1'b0, 1'b0), 1, "bne_eq");
    issue(32'hFFF08093, 0, 1'b0, mk(0, 5'd1, 5'd0, 1'b0, 5'd1, 32'hFFFFFFFF, 1'b1, 1'b1, 3'b000, 1'b1, 1'b0), 1, "addi_neg");
    issue(32'h00100013, 0, 1'b0, mk(0, 5'd0, 5'd0, 1'b0, 5'd0, 32'h1, 1'b1, 1'b1, 3'b000, 1'b0, 1'b0), 1, "addi_x0");

    // run dropped mid-fetch: the stalled request is still held and the instruction completes.
    run = 1'b0;
    issue(32'h007302B3, 2, 1'b0, mk(0, 5'd6, 5'd7, 1'b1, 5'd5, 32'h0, 1'b0, 1'b0, 3'b000, 1'b1, 1'b0), 0, "add_run0");
    seen = 1'b0;
    for (int k = 0; k < 3; k++) begin
      @(negedge clk);
      seen = seen | imem_req;
    end
    check("idle_no_req", seen, 0);
    run = 1'b1;

    // Reset while in EXEC of a taken branch.
    wait_req();
    EQ = 1'b0;
    sb.push_back(mk(0, 5'd10, 5'd0, 1'b1, 5'd29, 32'hFFFFFFFC, 1'b1, 1'b0, 3'b001, 1'b0, 1'b1));
    imem_ready = 1'b1;
    imem_instr = 32'hFE051EE3;
    @(negedge clk);
    imem_ready = 1'b0;
    n = 0;
    while (!pc_en && n < 10) begin
      @(negedge clk);
      n++;
    end
    check("rst_exec_pcsrc_before", {pc_en, PCsrc}, 2'b11);
    #2 rst = 1'b1;
    #1 check("rst_exec_zero", outs_vec(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_ret = 0;

    // Reset during a stalled fetch.
    wait_req();
    imem_ready = 1'b0;
    repeat (2) @(negedge clk);
    check("rst_fetch_req_before", imem_req, 1);
    #2 rst = 1'b1;
    #1 check("rst_fetch_zero", outs_vec(), 0);
    repeat (2) @(negedge clk);
    rst = 1'b0;
    exp_ret = 0;

    issue(32'h00500513, 0, 1'b0, mk(0, 5'd0, 5'd0, 1'b0, 5'd10, 32'h5, 1'b1, 1'b1, 3'b000, 1'b1, 1'b0), 1, "addi_after_rst");
    issue(32'h00000073, 0, 1'b0, mk(1, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0), 0, "ecall");
    check("halted_flag", {halted, trap}, 2'b10);
    do_reset("rst_halt");

    issue(32'hFFFFFFFF, 0, 1'b0, mk(2, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0), 0, "illegal_ff");
    check("trap_flag", {halted, trap}, 2'b01);
    do_reset("rst_trap");

    issue(32'h407302B3, 0, 1'b0, mk(2, 5'd0, 5'd0, 1'b0, 5'd0, 32'h0, 1'b0, 1'b0, 3'b000, 1'b0, 1'b0), 0, "illegal_f7");
    check("trap_flag_f7", {halted, trap}, 2'b01);
    do_reset("rst_trap2");

    check("sb_drained", sb.size(), 0);
    $display("%0d/%0d checks passed", n_pass, n_total);
    $finish;
  end

endmodule

// File: doc/multicycle_ctrl.md
Name: multicycle_ctrl

Overview:
- Multi-cycle controller that sequences the reduced RISC-V datapath (regfile, ALU, operand mux, PC register).
- Fetches each instruction over a valid/ready instruction-memory handshake and decodes it.
- Drives the datapath control and operand fields for exactly one EXEC cycle, gating the register write and the PC update.
- Supports ADDI, ADD and BNE; stops on ECALL (halt) or on an unsupported encoding (trap).

Parameters:
- DATA_WIDTH, 32, width of ImmOp and instruction word.
- REG_ADDRESS_WIDTH, 5, width of rs1/rs2/rd.
- RETIRE_WIDTH, 16, width of the retired-instruction counter.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- run  in  1  permits starting a new fetch.
- imem_req  out  1  fetch request; held until accepted.
- imem_ready  in  1  fetch accepted; imem_instr is valid this cycle.
- imem_instr  in  DATA_WIDTH  fetched instruction.
- EQ  in  1  ALU equality flag (rs1 == op2).
- ImmOp  out  DATA_WIDTH  sign-extended immediate.
- rs1, rs2, rd  out  REG_ADDRESS_WIDTH  register addresses.
- RegWrite  out  1  regfile write enable.
- ALUsrc  out  1  1 = ImmOp, 0 = rs2 data.
- ALUctrl  out  3  000 = add, 001 = sub.
- PCsrc  out  1  1 = PC+ImmOp, 0 = PC+4.
- pc_en  out  1  PC register load enable.
- halted  out  1  sticky, ECALL seen.
- trap  out  1  sticky, illegal instruction seen.
- retired  out  RETIRE_WIDTH  count of completed instructions.

Behaviour:
- Reset (async, any state, mid-handshake included): state=IDLE; all outputs 0; imem_req drops immediately; latched instruction cleared.

FSM states and transitions:
- IDLE -> FETCH when run=1.
- FETCH: imem_req=1. On an edge with imem_ready=1, latch imem_instr, go to DECODE.
  - imem_req is never withdrawn before acceptance, regardless of run.
- DECODE (1 cycle): register rs1, rs2, rd, ImmOp, ALUsrc, ALUctrl from the latched word. Then:
  - ECALL (0x00000073) -> HALT.
  - Unsupported encoding -> TRAP.
  - Otherwise -> EXEC.
- EXEC (1 cycle):
  - pc_en=1.
  - RegWrite=1 only for ADD/ADDI with rd!=0.
  - BNE: PCsrc = ~EQ, where EQ is sampled combinationally in EXEC; PCsrc=0 for other instructions.
  - retired increments at end of EXEC (wraps).
  - Next state: FETCH if run=1, else IDLE.
- HALT / TRAP: absorbing; halted or trap=1; pc_en=RegWrite=imem_req=0; exit only via rst.
- RegWrite, pc_en and PCsrc are 0 in every state except EXEC.
- Field outputs are stable from DECODE exit through EXEC and held until the next DECODE.

Decode rules:
- ADDI: opcode 0010011, funct3 000. ALUsrc=1, ALUctrl=000. ImmOp = sext(instr[31:20]).
- ADD: opcode 0110011, funct3 000, funct7 0000000. ALUsrc=0, ALUctrl=000.
- BNE: opcode 1100011, funct3 001. ALUsrc=0, ALUctrl=001. ImmOp = sext({i[31], i[7], i[30:25], i[11:8], 1'b0}).
- Anything else is illegal, including other funct3/funct7 values.

Timing:
- Minimum 3 cycles per instruction (FETCH with immediate ready, DECODE, EXEC).
- Each fetch-stall cycle adds 1.
- run=0 during FETCH/DECODE/EXEC does not abort the current instruction.

Test Plan:
- addi x10,x0,5 (0x00500513), ready immediate -> DECODE then EXEC: rs1=0, rd=10, ImmOp=0x00000005, ALUsrc=1, ALUctrl=000; RegWrite and pc_en high exactly 1 cycle; PCsrc=0; retired=1; next imem_req on cycle 4.
- add x5,x6,x7 (0x007302B3) -> rs1=6, rs2=7, rd=5, ALUsrc=0, ALUctrl=000, RegWrite pulse 1 cycle.
- bne x10,x0,-4 (0xFE051EE3), EQ=0 in EXEC -> ImmOp=0xFFFFFFFC, ALUctrl=001, PCsrc=1, pc_en=1, RegWrite=0.
  - Repeat with EQ=1 -> PCsrc=0.
- imem_ready low 4 cycles -> imem_req held high all 4 cycles, pc_en/RegWrite stay 0; instruction completes in 7 cycles.
- 0x00000073 -> halted=1, retired unchanged, no further imem_req.
  - 0xFFFFFFFF -> trap=1.
  - addi with rd=0 -> pc_en pulse, RegWrite stays 0.
- rst asserted during EXEC and during a stalled FETCH -> all outputs 0 immediately (before next edge); after release with run=1, fresh fetch and retired restarts from 0.
